// File: rtl/meas_pkg.sv
// Shared definitions for the measurement sequencer: state encoding,
// timeout counter widths and the BCD result width.
package meas_pkg;

  localparam int TO_MS_W  = 16;
  localparam int TO_CLK_W = 8;
  localparam int DATA_W   = 32;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_MEAS = 3'd1;
  localparam logic [2:0] ST_DIV  = 3'd2;
  localparam logic [2:0] ST_CONV = 3'd3;
  localparam logic [2:0] ST_HOLD = 3'd4;
  localparam logic [2:0] ST_ERR  = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE = ST_IDLE,
    S_MEAS = ST_MEAS,
    S_DIV  = ST_DIV,
    S_CONV = ST_CONV,
    S_HOLD = ST_HOLD,
    S_ERR  = ST_ERR
  } state_t;

endpackage

// File: rtl/meas_seq_ctrl_timeout.sv
// seq_timeout: up-counter with clear, tick select (ce1ms or every clk) and a
// terminal-count flag that fires on the tick that reaches the loaded terminal.
module seq_timeout
  import meas_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               run,
  input  logic               sel_ms,
  input  logic               ce1ms,
  input  logic [TO_MS_W-1:0] term,
  output logic               tc
);

  logic [TO_MS_W-1:0] tcnt;
  logic               tick;

  assign tick = run & (sel_ms ? ce1ms : 1'b1);
  assign tc   = tick & (tcnt == term);

  // clear has priority so a tick coincident with a state change is dropped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcnt <= '0;
    end else if (clr) begin
      tcnt <= '0;
    end else if (tick) begin
      tcnt <= tcnt + 1'b1;
    end
  end

endmodule

// File: rtl/meas_seq_ctrl.sv
// Measurement sequencer: measure -> divide -> convert -> hold, with timeouts,
// abort and a latched display result. Build option AUTO_RUN_EN re-arms MEAS.
module meas_seq_ctrl
  import meas_pkg::*;
#(
  parameter int MEAS_TO_MS   = 2000,
  parameter int STAGE_TO_CLK = 255,
  parameter int HOLD_MS      = 500
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce1ms,
  input  logic              start,
  input  logic              abort,
  input  logic              ce_end,
  input  logic              ok_div,
  input  logic              ok_dec,
  input  logic [DATA_W-1:0] f_dec,
  output logic              st_mes,
  output logic              st_div,
  output logic              st_dec,
  output logic [DATA_W-1:0] f_hold,
  output logic              valid,
  output logic              busy,
  output logic              err_to
);

  localparam logic [TO_MS_W-1:0] MEAS_TERM  = TO_MS_W'(MEAS_TO_MS - 1);
  localparam logic [TO_MS_W-1:0] STAGE_TERM = TO_MS_W'(TO_CLK_W'(STAGE_TO_CLK - 1));
  localparam logic [TO_MS_W-1:0] HOLD_TERM  = TO_MS_W'((HOLD_MS > 0) ? HOLD_MS - 1 : 0);
  localparam bit                 HOLD_NONE  = (HOLD_MS == 0);

  state_t             state, state_nx, rearm_st;
  logic               run, sel_ms, tc;
  logic [TO_MS_W-1:0] term;

  seq_timeout u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clr    (state_nx != state),
    .run    (run),
    .sel_ms (sel_ms),
    .ce1ms  (ce1ms),
    .term   (term),
    .tc     (tc)
  );

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // abort beats the stage's done pulse, which beats its timeout
  always_comb begin
    state_nx = state;
    run      = 1'b1;
    sel_ms   = 1'b1;
    term     = MEAS_TERM;
    rearm_st = S_IDLE;
`ifdef AUTO_RUN_EN
    if (start) rearm_st = S_MEAS;
`endif
    case (state)
      S_IDLE: begin
        run = 1'b0;
        if (start) state_nx = S_MEAS;
      end
      S_MEAS: begin
        if (abort)       state_nx = S_IDLE;
        else if (ce_end) state_nx = S_DIV;
        else if (tc)     state_nx = S_ERR;
      end
      S_DIV: begin
        sel_ms = 1'b0;
        term   = STAGE_TERM;
        if (abort)       state_nx = S_IDLE;
        else if (ok_div) state_nx = S_CONV;
        else if (tc)     state_nx = S_ERR;
      end
      S_CONV: begin
        sel_ms = 1'b0;
        term   = STAGE_TERM;
        if (abort)       state_nx = S_IDLE;
        else if (ok_dec) state_nx = S_HOLD;
        else if (tc)     state_nx = S_ERR;
      end
      S_HOLD: begin
        term = HOLD_TERM;
        if (abort)                 state_nx = S_IDLE;
        else if (HOLD_NONE || tc)  state_nx = rearm_st;
      end
      S_ERR: begin
        run = 1'b0;
        if (abort) state_nx = S_IDLE;
        else       state_nx = rearm_st;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // start pulses and the result latch are registered on the entry edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_mes <= 1'b0;
      st_div <= 1'b0;
      st_dec <= 1'b0;
      f_hold <= '0;
      valid  <= 1'b0;
      err_to <= 1'b0;
    end else begin
      st_mes <= (state_nx == S_MEAS) && (state != S_MEAS);
      st_div <= (state_nx == S_DIV)  && (state != S_DIV);
      st_dec <= (state_nx == S_CONV) && (state != S_CONV);
      if (state == S_CONV && state_nx == S_HOLD) begin
        f_hold <= f_dec;
        valid  <= 1'b1;
      end else if (state_nx == S_ERR && state != S_ERR) begin
        valid  <= 1'b0;
      end
      if (state_nx == S_ERR && state != S_ERR) begin
        err_to <= 1'b1;
      end else if (state_nx == S_MEAS && state != S_MEAS) begin
        err_to <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_meas_seq_ctrl.sv
// Bench for meas_seq_ctrl: directed vector table, multi-cycle corner cases and
// a randomized run against a behavioural sequence model.
module tb_meas_seq_ctrl;

  localparam int MEAS_TO  = 3;
  localparam int STAGE_TO = 8;
  localparam int HOLD     = 4;
`ifdef AUTO_RUN_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, ce1ms, start, abort, ce_end, ok_div, ok_dec;
  logic [31:0] f_dec, f_hold;
  logic        st_mes, st_div, st_dec, valid, busy, err_to;

  meas_seq_ctrl #(
    .MEAS_TO_MS  (MEAS_TO),
    .STAGE_TO_CLK(STAGE_TO),
    .HOLD_MS     (HOLD)
  ) dut (
    .clk(clk), .rst(rst), .ce1ms(ce1ms), .start(start), .abort(abort),
    .ce_end(ce_end), .ok_div(ok_div), .ok_dec(ok_dec), .f_dec(f_dec),
    .st_mes(st_mes), .st_div(st_div), .st_dec(st_dec), .f_hold(f_hold),
    .valid(valid), .busy(busy), .err_to(err_to)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // behavioural model: phase 0 idle,1 measure,2 divide,3 convert,4 hold,5 error
  int          ph = 0;
  int          elapsed = 0;
  bit          m_mes, m_div, m_dec, m_valid, m_err;
  logic [31:0] m_fh;

  // input vector order: {start, abort, ce1ms, ce_end, ok_div, ok_dec}
  // flag order: {st_mes, st_div, st_dec, busy, valid, err_to}
  typedef struct {
    logic [5:0]  in;
    logic [31:0] f;
    logic [5:0]  ef;
    logic [31:0] efh;
  } vec_t;

  vec_t tbl[19];

  task automatic model_reset();
    ph = 0; elapsed = 0;
    m_mes = 0; m_div = 0; m_dec = 0; m_valid = 0; m_err = 0; m_fh = '0;
  endtask

  task automatic model_edge(input logic [5:0] in, input logic [31:0] f);
    bit s, a, c, e, d, k;
    int nx;
    {s, a, c, e, d, k} = in;
    nx = ph;
    case (ph)
      0: if (s) nx = 1;
      1: if (a) nx = 0; else if (e) nx = 2; else if (c && elapsed + 1 == MEAS_TO) nx = 5;
      2: if (a) nx = 0; else if (d) nx = 3; else if (elapsed + 1 == STAGE_TO) nx = 5;
      3: if (a) nx = 0; else if (k) nx = 4; else if (elapsed + 1 == STAGE_TO) nx = 5;
      4: if (a) nx = 0; else if (HOLD == 0 || (c && elapsed + 1 == HOLD)) nx = (AUTO && s) ? 1 : 0;
      default: nx = (!a && AUTO && s) ? 1 : 0;
    endcase
    m_mes = (nx == 1 && ph != 1);
    m_div = (nx == 2 && ph != 2);
    m_dec = (nx == 3 && ph != 3);
    if (ph == 3 && nx == 4) begin m_fh = f; m_valid = 1; end
    if (nx == 5 && ph != 5) begin m_err = 1; m_valid = 0; end
    if (nx == 1 && ph != 1) m_err = 0;
    if (nx != ph) elapsed = 0;
    else if (ph == 2 || ph == 3 || c) elapsed++;
    ph = nx;
  endtask

  task automatic check(input string name, input logic [5:0] ef, input logic [31:0] efh);
    logic [5:0] af;
    af = {st_mes, st_div, st_dec, busy, valid, err_to};
    n_checks++;
    if (af !== ef || f_hold !== efh) begin
      n_err++;
      $display("FAIL %s: got flags=%b f_hold=%h, want flags=%b f_hold=%h (t=%0t)",
               name, af, f_hold, ef, efh, $time);
    end
  endtask

  task automatic model_check(input string name);
    check(name, {m_mes, m_div, m_dec, ph != 0, m_valid, m_err}, m_fh);
  endtask

  task automatic cyc(input logic [5:0] in, input logic [31:0] f);
    {start, abort, ce1ms, ce_end, ok_div, ok_dec} = in;
    f_dec = f;
    @(posedge clk);
    model_edge(in, f);
    #1;
  endtask

  initial begin
    tbl[0]  = '{6'b100000, 32'h0, 6'b100100, 32'h0};
    tbl[1]  = '{6'b001000, 32'h0, 6'b000100, 32'h0};
    tbl[2]  = '{6'b000100, 32'h0, 6'b010100, 32'h0};
    tbl[3]  = '{6'b000000, 32'h0, 6'b000100, 32'h0};
    tbl[4]  = '{6'b000010, 32'h0, 6'b001100, 32'h0};
    tbl[5]  = '{6'b000001, 32'h0001_2345, 6'b000110, 32'h0001_2345};
    tbl[6]  = '{6'b001000, 32'h0, 6'b000110, 32'h0001_2345};
    tbl[7]  = '{6'b001000, 32'h0, 6'b000110, 32'h0001_2345};
    tbl[8]  = '{6'b000000, 32'h0, 6'b000110, 32'h0001_2345};
    tbl[9]  = '{6'b001000, 32'h0, 6'b000110, 32'h0001_2345};
    tbl[10] = '{6'b001000, 32'h0, 6'b000010, 32'h0001_2345};
    tbl[11] = '{6'b000000, 32'h0, 6'b000010, 32'h0001_2345};
    tbl[12] = '{6'b100000, 32'h0, 6'b100110, 32'h0001_2345};
    tbl[13] = '{6'b001000, 32'h0, 6'b000110, 32'h0001_2345};
    tbl[14] = '{6'b001000, 32'h0, 6'b000110, 32'h0001_2345};
    tbl[15] = '{6'b001000, 32'h0, 6'b000101, 32'h0001_2345};
    tbl[16] = '{6'b000000, 32'h0, 6'b000001, 32'h0001_2345};
    tbl[17] = '{6'b100000, 32'h0, 6'b100100, 32'h0001_2345};
    tbl[18] = '{6'b010000, 32'h0, 6'b000000, 32'h0001_2345};

    rst = 1'b1;
    {start, abort, ce1ms, ce_end, ok_div, ok_dec} = '0;
    f_dec = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", 6'b000000, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // normal run, measurement timeout, err_to clear, abort in MEAS
    foreach (tbl[i]) begin
      cyc(tbl[i].in, tbl[i].f);
      check($sformatf("vec%0d", i), tbl[i].ef, tbl[i].efh);
    end

    // divider timeout lands exactly STAGE_TO cycles after DIV entry
    cyc(6'b100000, 0); check("to_start", 6'b100100, 32'h0001_2345);
    cyc(6'b000100, 0); check("to_div_entry", 6'b010100, 32'h0001_2345);
    for (int i = 1; i < STAGE_TO; i++) begin
      cyc(6'b000000, 0); check($sformatf("to_div_wait%0d", i), 6'b000100, 32'h0001_2345);
    end
    cyc(6'b000000, 0); check("to_div_expire", 6'b000101, 32'h0001_2345);
    cyc(6'b000000, 0); check("to_err_idle", 6'b000001, 32'h0001_2345);

    // done on the timeout cycle wins, then abort beats ok_dec in CONV
    cyc(6'b100000, 0); check("late_start", 6'b100100, 32'h0001_2345);
    cyc(6'b000100, 0); check("late_div", 6'b010100, 32'h0001_2345);
    for (int i = 1; i < STAGE_TO; i++) cyc(6'b000000, 0);
    cyc(6'b000010, 0); check("late_ok_div", 6'b001100, 32'h0001_2345);
    cyc(6'b010001, 32'h9999_9999); check("abort_vs_ok_dec", 6'b000000, 32'h0001_2345);
    cyc(6'b000001, 32'h7777_7777); check("idle_ok_dec_ignored", 6'b000000, 32'h0001_2345);

    // asynchronous reset between edges while in DIV
    cyc(6'b100000, 0); check("ar_start", 6'b100100, 32'h0001_2345);
    cyc(6'b000100, 0); check("ar_div", 6'b010100, 32'h0001_2345);
    {start, abort, ce1ms, ce_end, ok_div, ok_dec} = '0;
    #2 rst = 1'b1;
    #1 check("async_reset", 6'b000000, 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    cyc(6'b100000, 0); check("post_reset_start", 6'b100100, 32'h0);
    cyc(6'b000100, 0); check("post_reset_div", 6'b010100, 32'h0);
    cyc(6'b000010, 0); check("post_reset_conv", 6'b001100, 32'h0);
    cyc(6'b000001, 32'h0004_2424); check("post_reset_hold", 6'b000110, 32'h0004_2424);
    for (int i = 0; i < HOLD; i++) cyc(6'b001000, 0);
    check("post_reset_idle", 6'b000010, 32'h0004_2424);

`ifdef AUTO_RUN_EN
    // continuous measurement while start stays high
    cyc(6'b100000, 0); check("auto_start", 6'b100110, 32'h0004_2424);
    cyc(6'b100100, 0);
    cyc(6'b100010, 0);
    cyc(6'b100001, 32'h0005_4321); check("auto_hold", 6'b000110, 32'h0005_4321);
    for (int i = 0; i < HOLD; i++) cyc(6'b101000, 0);
    check("auto_rearm", 6'b100110, 32'h0005_4321);
    cyc(6'b000100, 0);
    cyc(6'b000010, 0);
    cyc(6'b000001, 32'h0001_1111);
    for (int i = 0; i < HOLD; i++) cyc(6'b001000, 0);
    check("auto_stop", 6'b000010, 32'h0001_1111);
`endif

    // randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      logic [5:0] in;
      in[5] = ($urandom_range(0, 9) < 3);
      in[4] = ($urandom_range(0, 49) == 0);
      in[3] = ($urandom_range(0, 3) == 0);
      in[2] = ($urandom_range(0, 9) == 0);
      in[1] = ($urandom_range(0, 9) == 0);
      in[0] = ($urandom_range(0, 9) == 0);
      cyc(in, $urandom);
      model_check($sformatf("rand%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
